// File: rtl/tx_sched.sv
// Round-robin scheduler feeding a parallel-load serial TX buffer.
// Each granted byte gets one load cycle, NBITS shift cycles, then GAP idle cycles.
module tx_sched #(
    parameter int NBITS = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [NBITS-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [NBITS-1:0] req1_data,
    output logic             req1_ready,
    input  logic             hold,
    output logic [NBITS-1:0] buf_din,
    output logic             buf_load,
    output logic             buf_en,
    output logic             busy,
    output logic             grant_id,
    output logic             done
);
    // Counters keep at least one bit so NBITS=1 / GAP=0 still elaborate.
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [GW-1:0] gcnt, gcnt_nxt;
    logic          last_grant;
    logic          win;
    logic          hs;

    // Tie goes to whoever was not served last.
    always_comb begin
        win = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        hs  = (state == S_IDLE) && (req0_valid || req1_valid) && !rst;
    end

    assign req0_ready = hs && !win;
    assign req1_ready = hs && win;

    assign buf_load = (state == S_LOAD);
    assign buf_en   = (state == S_SHIFT) && !hold;
    assign done     = buf_en && (cnt == CNT_LAST);
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        case (state)
            S_IDLE: begin
                if (hs) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_SHIFT;
                cnt_nxt   = '0;
            end
            S_SHIFT: begin
                if (buf_en) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        gcnt_nxt  = '0;
                        state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gcnt == GAP_LAST) begin
                    gcnt_nxt  = '0;
                    state_nxt = S_IDLE;
                end else begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            gcnt       <= '0;
            last_grant <= 1'b1;
            buf_din    <= '0;
            grant_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gcnt  <= gcnt_nxt;
            if (hs) begin
                buf_din    <= win ? req1_data : req0_data;
                grant_id   <= win;
                last_grant <= win;
            end
        end
    end
endmodule

// File: tb/tb_tx_sched.sv
// Bench for tx_sched: default (8,1) and small (4,0) instances share stimulus and
// are each checked every cycle against a count-based transaction model.
module tb_tx_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0, v1, hold;
    logic [7:0] d0, d1;
    wire  [1:0] rdy0, rdy1, load, en, busy, gid, done;
    wire  [7:0] din0;
    wire  [3:0] din1;

    tx_sched #(.NBITS(8), .GAP(1)) u0 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0[0]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1[0]),
        .hold(hold), .buf_din(din0), .buf_load(load[0]), .buf_en(en[0]),
        .busy(busy[0]), .grant_id(gid[0]), .done(done[0]));

    tx_sched #(.NBITS(4), .GAP(0)) u1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0[3:0]), .req0_ready(rdy0[1]),
        .req1_valid(v1), .req1_data(d1[3:0]), .req1_ready(rdy1[1]),
        .hold(hold), .buf_din(din1), .buf_load(load[1]), .buf_en(en[1]),
        .busy(busy[1]), .grant_id(gid[1]), .done(done[1]));

    int nb[2] = '{8, 4};
    int gp[2] = '{1, 0};

    // model: in-flight flag, cycles since handshake, shift cycles done, gap cycles done
    int         act[2], step[2], ens[2], gaps[2], mlast[2], mgid[2];
    logic [7:0] mdin[2];

    int  cyc, n_chk, n_fail;
    int  hs_cyc[2], done_cyc[2], encnt[2], prev_hs[2], prev_gid[2];
    bit  contend;

    task automatic chk(input string nm, input int k, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d (cycle %0d)", nm, k, a, e, cyc);
        end
    endtask

    int         w;
    logic [7:0] dk0, dk1, ddin;
    bit         xb, xl, xe, xd, xr0, xr1;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            dk0  = (k == 1) ? {4'b0, d0[3:0]} : d0;
            dk1  = (k == 1) ? {4'b0, d1[3:0]} : d1;
            ddin = (k == 1) ? {4'b0, din1} : din0;
            if (rst) begin
                act[k] = 0; mlast[k] = 1; mdin[k] = 8'h00; mgid[k] = 0;
            end
            w   = (v0 && v1) ? (1 - mlast[k]) : (v1 ? 1 : 0);
            xb  = act[k] != 0;
            xl  = xb && step[k] == 0;
            xe  = xb && step[k] > 0 && ens[k] < nb[k] && !hold;
            xd  = xe && ens[k] == nb[k] - 1;
            xr0 = !rst && !xb && v0 && w == 0;
            xr1 = !rst && !xb && v1 && w == 1;
            chk("busy", k, int'(busy[k]), int'(xb));
            chk("load", k, int'(load[k]), int'(xl));
            chk("en", k, int'(en[k]), int'(xe));
            chk("done", k, int'(done[k]), int'(xd));
            chk("ready0", k, int'(rdy0[k]), int'(xr0));
            chk("ready1", k, int'(rdy1[k]), int'(xr1));
            chk("din", k, int'(ddin), int'(mdin[k]));
            chk("grant_id", k, int'(gid[k]), mgid[k]);
            chk("ld_en_excl", k, int'(load[k] & en[k]), 0);

            if (load[k]) encnt[k] = 0;
            if (en[k]) encnt[k]++;
            if (done[k]) begin
                chk("en_per_byte", k, encnt[k], (k == 1) ? 4 : 8);
                done_cyc[k] = cyc;
            end
            if ((rdy0[k] && v0) || (rdy1[k] && v1)) begin
                hs_cyc[k] = cyc;
                if (contend) begin
                    if (prev_hs[k] >= 0) begin
                        chk("hs_spacing", k, cyc - prev_hs[k], (k == 1) ? 6 : 11);
                        chk("rr_order", k, int'(rdy1[k]), (prev_gid[k] == 0) ? 1 : 0);
                    end
                    prev_hs[k]  = cyc;
                    prev_gid[k] = int'(rdy1[k]);
                end
            end

            if (!rst) begin
                if (act[k] == 0) begin
                    if (v0 || v1) begin
                        act[k] = 1; step[k] = 0; ens[k] = 0; gaps[k] = 0;
                        mlast[k] = w; mgid[k] = w; mdin[k] = (w == 1) ? dk1 : dk0;
                    end
                end else if (step[k] == 0) begin
                    step[k] = 1;
                end else if (ens[k] < nb[k]) begin
                    if (!hold) begin
                        ens[k]++;
                        if (ens[k] == nb[k] && gp[k] == 0) act[k] = 0;
                    end
                end else begin
                    gaps[k]++;
                    if (gaps[k] == gp[k]) act[k] = 0;
                end
            end
        end
    end

    task automatic wait_hs();
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if ((rdy0[0] && v0) || (rdy1[0] && v1)) got = 1;
        end
        if (!got) chk("hs_timeout", 0, 0, 1);
    endtask

    task automatic wait_en(input int n);
        int c = 0;
        for (int i = 0; i < 40 && c < n; i++) begin
            @(negedge clk);
            if (en[0]) c++;
        end
        if (c < n) chk("en_timeout", 0, c, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v0 = 0; v1 = 0; hold = 0; d0 = 0; d1 = 0; contend = 0;
        prev_hs = '{-1, -1};
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("idle_busy", k, int'(busy[k]), 0);
            chk("idle_ready", k, int'(rdy0[k] | rdy1[k]), 0);
            chk("idle_gid", k, int'(gid[k]), 0);
        end
        chk("idle_din", 0, int'(din0), 0);

        // single byte: load, 8 en, done on the 8th, one gap cycle, idle
        @(posedge clk); #1 d0 = 8'hAA; v0 = 1;
        wait_hs();
        @(posedge clk); #1 v0 = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            chk("sb_load", i, int'(load[0]), int'(i == 1));
            chk("sb_en", i, int'(en[0]), int'(i >= 2 && i <= 9));
            chk("sb_done", i, int'(done[0]), int'(i == 9));
            chk("sb_busy", i, int'(busy[0]), int'(i <= 10));
            chk("sb_din", i, int'(din0), 8'hAA);
            chk("sb_gid", i, int'(gid[0]), 0);
        end

        // contention: both valid continuously
        @(posedge clk); #1 d0 = 8'hAA; d1 = 8'hCC; v0 = 1; v1 = 1; contend = 1;
        repeat (70) @(posedge clk);
        #1 contend = 0; v0 = 0; v1 = 0;
        repeat (15) @(posedge clk);

        // hold for 3 cycles after the 4th en cycle
        #1 d1 = 8'hCC; v1 = 1; done_cyc[0] = -100;
        wait_hs();
        @(posedge clk); #1 v1 = 0;
        wait_en(4);
        @(posedge clk); #1 hold = 1;
        repeat (3) @(posedge clk);
        #1 hold = 0;
        repeat (10) @(negedge clk);
        chk("hold_done_delay", 0, done_cyc[0] - hs_cyc[0], 12);
        chk("hold_gid", 0, int'(gid[0]), 1);
        chk("hold_din", 0, int'(din0), 8'hCC);
        repeat (5) @(posedge clk);

        // reset in the middle of shifting
        #1 d0 = 8'h55; v0 = 1;
        wait_hs();
        @(posedge clk); #1 v0 = 0;
        wait_en(5);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("rst_en", 0, int'(en[0]), 0);
        chk("rst_done", 0, int'(done[0]), 0);
        chk("rst_busy", 0, int'(busy[0]), 0);
        chk("rst_din", 0, int'(din0), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0; d0 = 8'h11; d1 = 8'h22; v0 = 1; v1 = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("tie_after_rst_r0", k, int'(rdy0[k]), 1);
            chk("tie_after_rst_r1", k, int'(rdy1[k]), 0);
        end
        @(posedge clk); #1 v0 = 0; v1 = 0;
        repeat (15) @(posedge clk);

        // randomized traffic with hold and occasional reset
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (!v0 || $urandom_range(3) == 0) begin v0 = 1'($urandom_range(1)); d0 = 8'($urandom); end
            if (!v1 || $urandom_range(3) == 0) begin v1 = 1'($urandom_range(1)); d1 = 8'($urandom); end
            hold = ($urandom_range(4) == 0);
            rst  = ($urandom_range(300) == 0);
        end
        @(posedge clk); #1 rst = 0; v0 = 0; v1 = 0; hold = 0;
        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_sched.md
# tx_sched

Two-requester scheduler that sequences the 8-bit parallel-load serial TX buffer. It accepts bytes from two sources over valid/ready handshakes and arbitrates round-robin between them. For each granted byte it drives the buffer's `din`/`load` for one cycle, then `en` for exactly NBITS shift cycles, then a programmable idle gap. It sits directly upstream of the TX buffer and owns every control input of that buffer.

## Interface
- NBITS, 8: bits shifted per byte; width of data ports; ≥1
- GAP, 1: idle cycles inserted after each byte's last shift cycle; ≥0
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  NBITS  requester 0 byte
- req0_ready  out  1  requester 0 byte accepted this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  NBITS  requester 1 byte
- req1_ready  out  1  requester 1 byte accepted this cycle
- hold  in  1  freeze shifting (flow control from line side)
- buf_din  out  NBITS  parallel data to TX buffer
- buf_load  out  1  one-cycle load strobe to TX buffer
- buf_en  out  1  shift enable to TX buffer
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  source of the byte currently in flight
- done  out  1  one-cycle pulse on the final shift cycle

## Operation
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - Winner = valid requester. If both are valid, winner = requester ≠ last_grant.
  - reqN_ready is high combinationally for the winner only, and only when the winner's valid is high.
  - On a handshake: buf_din ← winner data, grant_id ← winner, last_grant ← winner, next state LOAD.
- LOAD: buf_load=1 for exactly one cycle. Next state SHIFT, bit counter cleared to 0.
- SHIFT:
  - buf_en = ~hold.
  - The counter increments only on cycles with buf_en=1.
  - On the cycle where buf_en=1 and counter=NBITS-1: done=1. Next state is GAP, or IDLE if GAP=0.
  - hold=1 freezes the counter and the state, with buf_en=0. Multiple hold cycles are allowed.
- GAP: counts GAP cycles, then returns to IDLE. hold is ignored.
- buf_din and grant_id are registered and stay stable from LOAD until the next handshake.
- buf_load, buf_en, done and busy are decoded from the state register plus hold. There is no combinational path from reqN inputs to any buf_* output.
- Both ready outputs are 0 outside IDLE. Inputs presented during a busy period are neither dropped nor consumed; they wait.
- Counter width: $clog2(NBITS); gap counter width: $clog2(GAP+1).

## Timing
- Reset values, applied immediately on rst assertion (including mid-LOAD/SHIFT/GAP):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - buf_din=0, grant_id=0, buf_load=0, buf_en=0, done=0, busy=0, both counters=0.
  - An aborted byte is lost; no done pulse is issued for it.
- Handshake at edge T:
  - LOAD occupies cycle T→T+1.
  - buf_en is high for cycles T+1 … T+NBITS, absent hold.
  - done coincides with the last of those cycles.
  - GAP cycles follow.
  - IDLE is reached NBITS+GAP+1 cycles after the handshake edge.
- Minimum handshake-to-handshake spacing = NBITS+GAP+2 cycles (11 with defaults).
- buf_load and buf_en are never high in the same cycle.
- Exactly NBITS buf_en cycles occur per accepted byte, regardless of hold.
- hold rising during LOAD has no effect on LOAD; it applies from the first SHIFT cycle.
- busy=1 from the cycle after the handshake through the last GAP cycle.

## Test plan
- Reset/idle:
  - Stimulus: assert rst mid-run, then release with no valids.
  - Required: all outputs 0; ready outputs low; busy=0 indefinitely.
- Single byte:
  - Stimulus: req0 sends 8'hAA.
  - Required: buf_din=8'hAA, buf_load for 1 cycle, then buf_en for exactly 8 consecutive cycles, done on the 8th, 1 GAP cycle, then IDLE; grant_id=0.
- Contention:
  - Stimulus: req0 and req1 both hold valid, with bytes 8'hAA and 8'hCC.
  - Required: grant order 0,1,0,1…; handshakes exactly 11 cycles apart; no ready asserted while busy.
- Hold:
  - Stimulus: req1 sends 8'hCC; hold=1 for 3 cycles after the 4th en cycle.
  - Required: buf_en low for those 3 cycles; 8 en cycles total; done delayed by 3 cycles.
- Reset mid-shift:
  - Stimulus: assert rst after 5 en cycles.
  - Required: buf_en drops immediately, no done pulse, last_grant=1; after release, req0 wins the next tie.
- Parameters:
  - Stimulus: NBITS=4, GAP=0.
  - Required: 4 en cycles per byte; back-to-back handshakes 6 cycles apart.
